// File: rtl/mrv1_tw_barrier_ctl.sv
// Barrier controller for the SIMT thread-warp scheduler.
// Tracks NUM_BARRIERS_P named barriers, parks arriving warps in a stall mask
// until size_m1+1 warps have arrived, then releases all of them in one pulse.
module mrv1_tw_barrier_ctl #(
    parameter int NUM_TW_P       = 8,
    parameter int NUM_BARRIERS_P = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           twctl_barrier_vld_i,
    input  logic [$clog2(NUM_BARRIERS_P)-1:0] twctl_barrier_id_i,
    input  logic [$clog2(NUM_TW_P)-1:0]    twctl_barrier_size_m1_i,
    input  logic [$clog2(NUM_TW_P)-1:0]    twctl_twid_i,
    output logic [NUM_TW_P-1:0]            bar_stall_mask_o,
    output logic [NUM_BARRIERS_P-1:0]      bar_busy_o,
    output logic                           release_vld_o,
    output logic [$clog2(NUM_BARRIERS_P)-1:0] release_id_o,
    output logic [NUM_TW_P-1:0]            release_wmask_o,
    output logic                           err_vld_o
);

    localparam int twid_width_lp       = $clog2(NUM_TW_P);
    localparam int barrier_id_width_lp = $clog2(NUM_BARRIERS_P);

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    state_t                   state_q   [NUM_BARRIERS_P];
    state_t                   state_n   [NUM_BARRIERS_P];
    logic [twid_width_lp-1:0] cnt_q     [NUM_BARRIERS_P];
    logic [twid_width_lp-1:0] cnt_n     [NUM_BARRIERS_P];
    logic [twid_width_lp-1:0] size_q    [NUM_BARRIERS_P];
    logic [twid_width_lp-1:0] size_n    [NUM_BARRIERS_P];
    logic [NUM_TW_P-1:0]      wmask_q   [NUM_BARRIERS_P];
    logic [NUM_TW_P-1:0]      wmask_n   [NUM_BARRIERS_P];

    logic [NUM_TW_P-1:0]            warp_onehot;
    logic [NUM_TW_P-1:0]            cur_stall;
    logic [NUM_TW_P-1:0]            stall_n;
    logic [NUM_BARRIERS_P-1:0]      busy_n;
    logic                           range_err;
    logic                           dup_err;
    logic                           accept;
    logic                           rel_vld_n;
    logic [barrier_id_width_lp-1:0] rel_id_n;
    logic [NUM_TW_P-1:0]            rel_wmask_n;
    logic                           err_n;

    // Decode the arrival, classify errors and compute every barrier's next state.
    always_comb begin
        warp_onehot = NUM_TW_P'(1) << twctl_twid_i;
        cur_stall   = '0;
        for (int b = 0; b < NUM_BARRIERS_P; b++) begin
            cur_stall = cur_stall | wmask_q[b];
        end
        // Out-of-range ids only exist for non-power-of-2 configurations.
        range_err = (int'(twctl_twid_i) >= NUM_TW_P) ||
                    (int'(twctl_barrier_id_i) >= NUM_BARRIERS_P);
        dup_err   = |(cur_stall & warp_onehot);
        accept    = twctl_barrier_vld_i && !range_err && !dup_err;

        state_n     = state_q;
        cnt_n       = cnt_q;
        size_n      = size_q;
        wmask_n     = wmask_q;
        rel_vld_n   = 1'b0;
        rel_id_n    = '0;
        rel_wmask_n = '0;
        err_n       = twctl_barrier_vld_i && (range_err || dup_err);

        for (int b = 0; b < NUM_BARRIERS_P; b++) begin
            if (accept && (int'(twctl_barrier_id_i) == b)) begin
                if (state_q[b] == IDLE) begin
                    if (twctl_barrier_size_m1_i == '0) begin
                        // Single-participant barrier: release without ever parking.
                        rel_vld_n   = 1'b1;
                        rel_id_n    = twctl_barrier_id_i;
                        rel_wmask_n = warp_onehot;
                    end else begin
                        state_n[b] = COLLECT;
                        size_n[b]  = twctl_barrier_size_m1_i;
                        cnt_n[b]   = twid_width_lp'(1);
                        wmask_n[b] = warp_onehot;
                    end
                end else begin
                    // A size mismatch is flagged but counted against the latched size.
                    if (twctl_barrier_size_m1_i != size_q[b]) begin
                        err_n = 1'b1;
                    end
                    if (cnt_q[b] == size_q[b]) begin
                        rel_vld_n   = 1'b1;
                        rel_id_n    = twctl_barrier_id_i;
                        rel_wmask_n = wmask_q[b] | warp_onehot;
                        state_n[b]  = IDLE;
                        cnt_n[b]    = '0;
                        wmask_n[b]  = '0;
                    end else begin
                        cnt_n[b]   = cnt_q[b] + 1'b1;
                        wmask_n[b] = wmask_q[b] | warp_onehot;
                    end
                end
            end
        end

        stall_n = '0;
        for (int b = 0; b < NUM_BARRIERS_P; b++) begin
            stall_n   = stall_n | wmask_n[b];
            busy_n[b] = (state_n[b] == COLLECT);
        end
    end

    // Barrier state and registered outputs; reset discards parked warps silently.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int b = 0; b < NUM_BARRIERS_P; b++) begin
                state_q[b] <= IDLE;
                cnt_q[b]   <= '0;
                wmask_q[b] <= '0;
            end
            bar_stall_mask_o <= '0;
            bar_busy_o       <= '0;
            release_vld_o    <= 1'b0;
            release_id_o     <= '0;
            release_wmask_o  <= '0;
            err_vld_o        <= 1'b0;
        end else begin
            for (int b = 0; b < NUM_BARRIERS_P; b++) begin
                state_q[b] <= state_n[b];
                cnt_q[b]   <= cnt_n[b];
                wmask_q[b] <= wmask_n[b];
            end
            bar_stall_mask_o <= stall_n;
            bar_busy_o       <= busy_n;
            release_vld_o    <= rel_vld_n;
            release_id_o     <= rel_id_n;
            release_wmask_o  <= rel_wmask_n;
            err_vld_o        <= err_n;
        end
    end

    // Latched participant count; only meaningful while the slot is collecting.
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < NUM_BARRIERS_P; b++) begin
            size_q[b] <= size_n[b];
        end
    end

endmodule
